mem_access_ctrl: RTL and testbench

//  Execute-side consumer of the decoded control word (MemRead, MemWrite, mem_to_reg,

---
 rtl/mem_access_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Execute-side memory access controller: runs one load/store at a time over a
// req/ack handshake and returns a single writeback (plus RET target) per instruction.
module mem_access_ctrl #(
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              mem_to_reg,
    input  logic              RegWrite,
    input  logic              rtrn,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] store_data,
    input  logic [3:0]        dst_reg,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              wb_valid,
    output logic              wb_en,
    output logic [3:0]        wb_dst,
    output logic [DATA_W-1:0] wb_data,
    output logic              ret_valid,
    output logic [DATA_W-1:0] ret_target,
    output logic              bus_err
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    localparam logic [7:0] TMAX = 8'(TIMEOUT);

    state_e            state_q, state_d;
    logic [7:0]        timer_q, timer_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              wbv_q, wbv_d;
    logic              wbe_q, wbe_d;
    logic [3:0]        wbdst_q, wbdst_d;
    logic [DATA_W-1:0] wbdata_q, wbdata_d;
    logic              retv_q, retv_d;
    logic [DATA_W-1:0] rett_q, rett_d;
    logic              err_q, err_d;
    // Control bits of the in-flight memory op, needed again at completion
    logic              m2r_q, m2r_d;
    logic              regw_q, regw_d;
    logic              isret_q, isret_d;
    logic [3:0]        dst_q, dst_d;

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wbv_d    = 1'b0;
        wbe_d    = 1'b0;
        wbdst_d  = wbdst_q;
        wbdata_d = wbdata_q;
        retv_d   = 1'b0;
        rett_d   = rett_q;
        err_d    = 1'b0;
        m2r_d    = m2r_q;
        regw_d   = regw_q;
        isret_d  = isret_q;
        dst_d    = dst_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (MemRead && MemWrite) begin
                        err_d = 1'b1;
                    end else if (MemRead || MemWrite) begin
                        state_d = BUSY;
                        timer_d = 8'd0;
                        req_d   = 1'b1;
                        we_d    = MemWrite;
                        addr_d  = alu_result;
                        wdata_d = store_data;
                        m2r_d   = mem_to_reg;
                        regw_d  = RegWrite;
                        isret_d = rtrn && MemRead;
                        dst_d   = dst_reg;
                    end else begin
                        wbv_d    = 1'b1;
                        wbe_d    = RegWrite;
                        wbdata_d = alu_result;
                        wbdst_d  = dst_reg;
                    end
                end
            end
            BUSY: begin
                // An ack arriving on the timeout edge still completes normally
                if (mem_ack) begin
                    state_d  = IDLE;
                    req_d    = 1'b0;
                    we_d     = 1'b0;
                    wbv_d    = 1'b1;
                    wbe_d    = regw_q;
                    wbdst_d  = dst_q;
                    wbdata_d = m2r_q ? mem_rdata : addr_q;
                    if (isret_q) begin
                        retv_d = 1'b1;
                        rett_d = mem_rdata;
                    end
                end else if (timer_q == TMAX - 8'd1) begin
                    state_d = IDLE;
                    timer_d = TMAX;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    err_d   = 1'b1;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wbv_q    <= 1'b0;
            wbe_q    <= 1'b0;
            wbdst_q  <= '0;
            wbdata_q <= '0;
            retv_q   <= 1'b0;
            rett_q   <= '0;
            err_q    <= 1'b0;
            m2r_q    <= 1'b0;
            regw_q   <= 1'b0;
            isret_q  <= 1'b0;
            dst_q    <= '0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wbv_q    <= wbv_d;
            wbe_q    <= wbe_d;
            wbdst_q  <= wbdst_d;
            wbdata_q <= wbdata_d;
            retv_q   <= retv_d;
            rett_q   <= rett_d;
            err_q    <= err_d;
            m2r_q    <= m2r_d;
            regw_q   <= regw_d;
            isret_q  <= isret_d;
            dst_q    <= dst_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign mem_req    = req_q;
    assign mem_we     = we_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign wb_valid   = wbv_q;
    assign wb_en      = wbe_q;
    assign wb_dst     = wbdst_q;
    assign wb_data    = wbdata_q;
    assign ret_valid  = retv_q;
    assign ret_target = rett_q;
    assign bus_err    = err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed table, randomized instructions against a
// transaction-level model, plus reset corner sequences.
module tb_mem_access_ctrl;

    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        MemRead, MemWrite, mem_to_reg, RegWrite, rtrn;
    logic [15:0] alu_result, store_data;
    logic [3:0]  dst_reg;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ack;
    logic        wb_valid, wb_en;
    logic [3:0]  wb_dst;
    logic [15:0] wb_data;
    logic        ret_valid;
    logic [15:0] ret_target;
    logic        bus_err;

    mem_access_ctrl #(.DATA_W(16), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .MemRead(MemRead), .MemWrite(MemWrite),
        .mem_to_reg(mem_to_reg), .RegWrite(RegWrite), .rtrn(rtrn),
        .alu_result(alu_result), .store_data(store_data), .dst_reg(dst_reg),
        .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .wb_valid(wb_valid), .wb_en(wb_en),
        .wb_dst(wb_dst), .wb_data(wb_data),
        .ret_valid(ret_valid), .ret_target(ret_target),
        .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd, wr, m2r, rw, rt;
        logic [15:0] alu, sd, rdata;
        logic [3:0]  dst;
        int          d;     // req cycle index carrying the ack; <0 = never
    } vec_t;

    typedef struct {
        int          cyc;   // cycle after accept where the result shows
        bit          err;
        bit          wb;
        logic        wb_en;
        logic [15:0] wb_data;
        logic [3:0]  dst;
        bit          ret;
        logic [15:0] ret_t;
        int          reqs;
    } exp_t;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input vec_t v);
        exp_t e;
        e = '{default: 0};
        if (v.rd && v.wr) begin
            e.cyc = 1; e.err = 1;
        end else if (!v.rd && !v.wr) begin
            e.cyc = 1; e.wb = 1; e.wb_en = v.rw;
            e.wb_data = v.alu; e.dst = v.dst;
        end else if (v.d >= 0 && v.d < TIMEOUT) begin
            e.cyc = v.d + 2; e.wb = 1; e.wb_en = v.rw;
            e.wb_data = v.m2r ? v.rdata : v.alu; e.dst = v.dst;
            e.ret = v.rt && v.rd; e.ret_t = v.rdata;
            e.reqs = v.d + 1;
        end else begin
            e.cyc = TIMEOUT + 1; e.err = 1; e.reqs = TIMEOUT;
        end
        return e;
    endfunction

    task automatic drive_fields(input vec_t v);
        MemRead = v.rd; MemWrite = v.wr; mem_to_reg = v.m2r;
        RegWrite = v.rw; rtrn = v.rt;
        alu_result = v.alu; store_data = v.sd; dst_reg = v.dst;
    endtask

    // Called at #1 after an edge; leaves the bench in the result cycle
    task automatic run(input vec_t v);
        exp_t e;
        vec_t junk;
        int   cyc, reqn;
        bit   done, stable, hit;
        e = model(v);
        check("in_ready_at_issue", {31'd0, in_ready}, 1);
        drive_fields(v);
        in_valid  = 1'b1;
        mem_ack   = 1'($urandom % 2);
        mem_rdata = 16'($urandom);
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 1; reqn = 0; stable = 1; done = 0;
        while (!done && cyc <= TIMEOUT + 4) begin
            if (mem_req) begin
                reqn++;
                if (mem_addr !== v.alu || mem_we !== v.wr ||
                    (v.wr && mem_wdata !== v.sd))
                    stable = 0;
            end
            if (wb_valid || bus_err) begin
                done = 1;
            end else begin
                hit       = mem_req && (reqn - 1 == v.d);
                mem_ack   = mem_req ? hit : 1'($urandom % 2);
                mem_rdata = hit ? v.rdata : 16'($urandom);
                in_valid  = mem_req ? 1'($urandom % 2) : 1'b0;
                junk = '{1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                         1'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                         4'($urandom), 0};
                drive_fields(junk);
                @(posedge clk); #1;
                cyc++;
            end
        end
        mem_ack  = 1'b0;
        in_valid = 1'b0;
        check("result_seen", {31'd0, done}, 1);
        check("result_cycle", cyc, e.cyc);
        check("bus_err", {31'd0, bus_err}, {31'd0, e.err});
        check("wb_valid", {31'd0, wb_valid}, {31'd0, e.wb});
        check("ret_valid", {31'd0, ret_valid}, {31'd0, e.ret});
        check("req_cycles", reqn, e.reqs);
        check("req_stable", {31'd0, stable}, 1);
        if (e.wb) begin
            check("wb_en", {31'd0, wb_en}, {31'd0, e.wb_en});
            check("wb_data", {16'd0, wb_data}, {16'd0, e.wb_data});
            check("wb_dst", {28'd0, wb_dst}, {28'd0, e.dst});
        end
        if (e.ret)
            check("ret_target", {16'd0, ret_target}, {16'd0, e.ret_t});
    endtask

    vec_t tbl[10];
    vec_t rv;
    int   evts;

    initial begin
        rst = 1'b1; in_valid = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
        drive_fields('{0, 0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 4'h0, 0});

        //            rd wr m2r rw rt  alu       sd        rdata     dst   d
        tbl[0] = '{0, 0, 0, 1, 0, 16'h1234, 16'h0000, 16'h0000, 4'd3,  0};
        tbl[1] = '{1, 0, 1, 1, 0, 16'h0040, 16'h0000, 16'hBEEF, 4'd5,  3};
        tbl[2] = '{0, 1, 0, 0, 0, 16'h0010, 16'hA5A5, 16'h0000, 4'd0,  2};
        tbl[3] = '{1, 0, 1, 0, 1, 16'h00FE, 16'h0000, 16'h0200, 4'd0,  1};
        tbl[4] = '{1, 0, 1, 1, 0, 16'h0080, 16'h0000, 16'h1111, 4'd7, -1};
        tbl[5] = '{1, 1, 0, 1, 0, 16'h0020, 16'h5555, 16'h0000, 4'd2,  0};
        tbl[6] = '{1, 0, 1, 1, 0, 16'h0090, 16'h0000, 16'h7E57, 4'd9, 14};
        tbl[7] = '{0, 1, 0, 1, 0, 16'h0030, 16'h3C3C, 16'h0000, 4'd4,  0};
        tbl[8] = '{0, 0, 0, 0, 0, 16'hFFFF, 16'h0000, 16'h0000, 4'd15, 0};
        tbl[9] = '{1, 0, 0, 1, 0, 16'h4321, 16'h0000, 16'h9999, 4'd6, 13};

        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 1);
        check("rst_mem_req", {31'd0, mem_req}, 0);
        check("rst_wb_valid", {31'd0, wb_valid}, 0);
        check("rst_bus_err", {31'd0, bus_err}, 0);
        check("rst_addr", {16'd0, mem_addr}, 0);
        check("rst_wb_data", {16'd0, wb_data}, 0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) run(tbl[i]);

        for (int i = 0; i < 80; i++) begin
            int op;
            op = int'($urandom_range(0, 7));
            rv.rd  = (op == 1 || op == 2 || op == 3 || op == 7);
            rv.wr  = (op == 4 || op == 5 || op == 7);
            rv.m2r = 1'($urandom); rv.rw = 1'($urandom); rv.rt = 1'($urandom);
            rv.alu = 16'($urandom); rv.sd = 16'($urandom);
            rv.rdata = 16'($urandom); rv.dst = 4'($urandom);
            rv.d = int'($urandom_range(0, 20));
            run(rv);
        end

        // Reset two cycles into BUSY drops the op silently
        rv = '{1, 0, 1, 1, 1, 16'h0044, 16'h0, 16'hCAFE, 4'd8, -1};
        drive_fields(rv);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("busy_req", {31'd0, mem_req}, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_req", {31'd0, mem_req}, 0);
        check("midrst_we", {31'd0, mem_we}, 0);
        check("midrst_ready", {31'd0, in_ready}, 1);
        check("midrst_addr", {16'd0, mem_addr}, 0);
        check("midrst_wb", {31'd0, wb_valid}, 0);
        check("midrst_err", {31'd0, bus_err}, 0);
        evts = 0;
        for (int i = 0; i < TIMEOUT + 4; i++) begin
            if (wb_valid || bus_err || ret_valid || mem_req) evts++;
            @(posedge clk); #1;
        end
        check("midrst_quiet", evts, 0);

        run(tbl[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

endmodule
